// File: rtl/ceres_param.sv
// Ceres shared parameters and types.
// Uncached access error codes and default timeout.
package ceres_param;

  localparam int XLEN = 32;
  localparam int UC_TIMEOUT_DEFAULT = 256;

  typedef enum logic [1:0] {
    UC_ERR_NONE    = 2'd0,
    UC_ERR_ACCESS  = 2'd1,
    UC_ERR_EXEC    = 2'd2,
    UC_ERR_TIMEOUT = 2'd3
  } uc_err_e;

endpackage

// File: rtl/uncached_access_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
// Search starts at ptr_i and wraps at NUM_REQ-1.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               valid_o
);

  int j;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr_i) + i) % NUM_REQ;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uncached_access_ctrl.sv
// Uncached access sequencer: arbitrate, PMA check,
// single-beat bus transfer with timeout, respond.
module uncached_access_ctrl
  import ceres_param::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = UC_TIMEOUT_DEFAULT,
  parameter int XLEN           = ceres_param::XLEN
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ-1:0]      req_exec_i,
  input  logic [NUM_REQ-1:0]      req_we_i,
  input  logic [NUM_REQ*XLEN-1:0] req_addr_i,
  input  logic [NUM_REQ*XLEN-1:0] req_wdata_i,
  input  logic [NUM_REQ*4-1:0]    req_wstrb_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  output logic [XLEN-1:0]         rsp_rdata_o,
  output logic [1:0]              rsp_err_o,
  output logic [XLEN-1:0]         pma_addr_o,
  input  logic                    pma_uncached_i,
  input  logic                    pma_memregion_i,
  input  logic                    pma_grand_i,
  output logic                    bus_valid_o,
  input  logic                    bus_ready_i,
  output logic                    bus_we_o,
  output logic [XLEN-1:0]         bus_addr_o,
  output logic [XLEN-1:0]         bus_wdata_o,
  output logic [3:0]              bus_wstrb_o,
  input  logic                    bus_rsp_valid_i,
  input  logic [XLEN-1:0]         bus_rdata_i,
  input  logic                    bus_err_i
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q;
  logic [IW-1:0]     rr_q;
  logic [IW-1:0]     win_q;
  logic              exec_q;
  logic              we_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [3:0]        wstrb_q;
  logic [CW-1:0]     cnt_q;
  logic              bus_valid_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [XLEN-1:0]   rdata_q;
  uc_err_e           err_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_vld;
  logic [NUM_REQ-1:0] win_oh;
  logic               expire;
  logic [IW-1:0]      rr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (rr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_vld)
  );

  assign win_oh  = NUM_REQ'(1) << win_q;
  assign expire  = cnt_q >= CNT_LAST;
  assign rr_next = (win_q == IW'(NUM_REQ - 1))
                 ? '0 : win_q + 1'b1;

  // Timeout counter saturates so ISSUE->WAIT at expiry still times out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      win_q       <= '0;
      exec_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      cnt_q       <= '0;
      bus_valid_q <= 1'b0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      err_q       <= UC_ERR_NONE;
    end else begin
      rsp_valid_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            win_q   <= gnt_idx;
            exec_q  <= req_exec_i[gnt_idx];
            we_q    <= req_we_i[gnt_idx];
            addr_q  <= req_addr_i[gnt_idx*XLEN +: XLEN];
            wdata_q <= req_wdata_i[gnt_idx*XLEN +: XLEN];
            wstrb_q <= req_wstrb_i[gnt_idx*4 +: 4];
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!pma_memregion_i || !pma_uncached_i) begin
            err_q       <= UC_ERR_ACCESS;
            rdata_q     <= '0;
            rsp_valid_q <= win_oh;
            state_q     <= S_RESP;
          end else if (exec_q && !pma_grand_i) begin
            err_q       <= UC_ERR_EXEC;
            rdata_q     <= '0;
            rsp_valid_q <= win_oh;
            state_q     <= S_RESP;
          end else begin
            cnt_q       <= '0;
            bus_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
          if (bus_ready_i) begin
            bus_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end else if (expire) begin
            bus_valid_q <= 1'b0;
            err_q       <= UC_ERR_TIMEOUT;
            rdata_q     <= '0;
            rsp_valid_q <= win_oh;
            state_q     <= S_RESP;
          end
        end
        S_WAIT: begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
          if (bus_rsp_valid_i) begin
            err_q       <= bus_err_i ? UC_ERR_ACCESS : UC_ERR_NONE;
            rdata_q     <= bus_err_i ? '0 : bus_rdata_i;
            rsp_valid_q <= win_oh;
            state_q     <= S_RESP;
          end else if (expire) begin
            err_q       <= UC_ERR_TIMEOUT;
            rdata_q     <= '0;
            rsp_valid_q <= win_oh;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          rr_q    <= rr_next;
          err_q   <= UC_ERR_NONE;
          rdata_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = (rst_ni && state_q == S_IDLE) ? gnt : '0;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign pma_addr_o  = addr_q;
  assign bus_valid_o = bus_valid_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_uncached_access_ctrl.sv
// Directed bench for uncached_access_ctrl.
// PMA and bus are modelled at the negedge.
module tb_uncached_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  req_valid_i = '0;
  logic [1:0]  req_exec_i = '0;
  logic [1:0]  req_we_i = '0;
  logic [63:0] req_addr_i = '0;
  logic [63:0] req_wdata_i = '0;
  logic [7:0]  req_wstrb_i = '0;
  logic [1:0]  req_ready_o;
  logic [1:0]  rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_err_o;
  logic [31:0] pma_addr_o;
  logic        pma_uncached_i = 1'b0;
  logic        pma_memregion_i = 1'b0;
  logic        pma_grand_i = 1'b0;
  logic        bus_valid_o;
  logic        bus_ready_i = 1'b0;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_wstrb_o;
  logic        bus_rsp_valid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_err_i = 1'b0;

  uncached_access_ctrl #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (8),
    .XLEN           (32)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_exec_i      (req_exec_i),
    .req_we_i        (req_we_i),
    .req_addr_i      (req_addr_i),
    .req_wdata_i     (req_wdata_i),
    .req_wstrb_i     (req_wstrb_i),
    .req_ready_o     (req_ready_o),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_rdata_o     (rsp_rdata_o),
    .rsp_err_o       (rsp_err_o),
    .pma_addr_o      (pma_addr_o),
    .pma_uncached_i  (pma_uncached_i),
    .pma_memregion_i (pma_memregion_i),
    .pma_grand_i     (pma_grand_i),
    .bus_valid_o     (bus_valid_o),
    .bus_ready_i     (bus_ready_i),
    .bus_we_o        (bus_we_o),
    .bus_addr_o      (bus_addr_o),
    .bus_wdata_o     (bus_wdata_o),
    .bus_wstrb_o     (bus_wstrb_o),
    .bus_rsp_valid_i (bus_rsp_valid_i),
    .bus_rdata_i     (bus_rdata_i),
    .bus_err_i       (bus_err_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rsp_cnt = 0;
  int multi = 0;
  int gq[$];
  bit bv_seen = 1'b0;
  bit pend = 1'b0;
  bit rsp_en = 1'b1;
  bit ready_en = 1'b1;
  bit late_rsp = 1'b0;
  bit rsp_err = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        cap_we = 1'b0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               tag, act, exp);
    end
  endtask

  // PMA map: 0x2xxx_xxxx uncached peripherals,
  // 0x8xxx_xxxx cacheable RAM, 0x2000_Axxx hole,
  // 0x2000_4xxx and the hole not executable.
  always @(negedge clk) begin
    pma_uncached_i  = pma_addr_o[31:28] == 4'h2;
    pma_memregion_i =
      (pma_addr_o[31:28] == 4'h2 &&
       pma_addr_o[31:12] != 20'h2000A) ||
      pma_addr_o[31:28] == 4'h8;
    pma_grand_i =
      !(pma_addr_o[31:12] == 20'h20004 ||
        pma_addr_o[31:12] == 20'h2000A);
    bus_rsp_valid_i = 1'b0;
    bus_err_i       = 1'b0;
    bus_rdata_i     = '0;
    if (!rst_ni) begin
      pend = 1'b0;
    end else if (pend && rsp_en) begin
      bus_rsp_valid_i = 1'b1;
      bus_rdata_i     = rsp_data;
      bus_err_i       = rsp_err;
      pend            = 1'b0;
    end else if (late_rsp) begin
      bus_rsp_valid_i = 1'b1;
      bus_rdata_i     = 32'hDEAD_BEEF;
    end
    bus_ready_i = rst_ni && bus_valid_o && ready_en;
    if (bus_ready_i) begin
      pend      = 1'b1;
      cap_we    = bus_we_o;
      cap_addr  = bus_addr_o;
      cap_wdata = bus_wdata_o;
      cap_wstrb = bus_wstrb_o;
    end
  end

  always @(negedge clk) begin
    #2;
    if (req_ready_o != 2'b00) begin
      gq.push_back(req_ready_o[1] ? 1 : 0);
      if (req_ready_o == 2'b11) multi++;
    end
    if (rsp_valid_o != 2'b00) rsp_cnt++;
    if (bus_valid_o) bv_seen = 1'b1;
  end

  task automatic issue(input int r, input bit ex,
                       input bit we,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [3:0] ws);
    bit got = 1'b0;
    @(negedge clk);
    req_exec_i[r] = ex;
    req_we_i[r] = we;
    req_addr_i[r*32 +: 32] = a;
    req_wdata_i[r*32 +: 32] = wd;
    req_wstrb_i[r*4 +: 4] = ws;
    req_valid_i[r] = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      if (k > 0) @(negedge clk);
      #3;
      if (req_ready_o[r]) begin
        got = 1'b1;
        acc_cyc = cyc;
      end
    end
    check("accept", 32'(got), 32'd1);
  endtask

  task automatic wait_rsp(input int r,
                          output logic [1:0] err,
                          output logic [31:0] rd,
                          output int lat);
    bit got = 1'b0;
    err = '0;
    rd = '0;
    lat = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      req_valid_i[r] = 1'b0;
      #3;
      if (rsp_valid_o[r]) begin
        got = 1'b1;
        err = rsp_err_o;
        rd = rsp_rdata_o;
        lat = cyc - acc_cyc;
      end
    end
    check("rsp_seen", 32'(got), 32'd1);
  endtask

  task automatic wait_grants(input int n);
    for (int k = 0; k < 200 && gq.size() < n; k++) begin
      @(negedge clk);
      #3;
    end
  endtask

  logic [1:0]  e;
  logic [31:0] d;
  int          l;
  int          rc;

  initial begin
    #3;
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_rspv", 32'(rsp_valid_o), 32'd0);
    check("rst_busv", 32'(bus_valid_o), 32'd0);
    check("rst_err", 32'(rsp_err_o), 32'd0);
    check("rst_pma", pma_addr_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    rsp_data = 32'hA5A5_0001;
    issue(1, 1'b0, 1'b0, 32'h2000_0004, 32'h0, 4'hF);
    wait_rsp(1, e, d, l);
    check("t1_err", 32'(e), 32'd0);
    check("t1_data", d, 32'hA5A5_0001);
    check("t1_lat", 32'(l), 32'd4);
    check("t1_addr", cap_addr, 32'h2000_0004);
    check("t1_we", 32'(cap_we), 32'd0);

    rsp_data = 32'h0;
    issue(1, 1'b0, 1'b1, 32'h2000_0008,
          32'h1234_5678, 4'h3);
    wait_rsp(1, e, d, l);
    check("t1w_err", 32'(e), 32'd0);
    check("t1w_lat", 32'(l), 32'd4);
    check("t1w_we", 32'(cap_we), 32'd1);
    check("t1w_wdata", cap_wdata, 32'h1234_5678);
    check("t1w_wstrb", 32'(cap_wstrb), 32'd3);

    @(negedge clk);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    gq.delete();
    multi = 0;
    rsp_data = 32'h0000_0055;
    req_exec_i = 2'b00;
    req_we_i = 2'b00;
    req_addr_i = {32'h2000_0200, 32'h2000_0100};
    req_valid_i = 2'b11;
    wait_grants(6);
    @(negedge clk);
    req_valid_i = 2'b00;
    repeat (10) @(negedge clk);
    check("t2_ngnt", 32'(gq.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_gnt%0d", i),
            32'((i < gq.size()) ? gq[i] : 99),
            32'(i % 2));
    end
    check("t2_multi", 32'(multi), 32'd0);

    bv_seen = 1'b0;
    issue(0, 1'b1, 1'b0, 32'h2000_4000, 32'h0, 4'hF);
    wait_rsp(0, e, d, l);
    check("t3_err", 32'(e), 32'd2);
    check("t3_lat", 32'(l), 32'd2);
    check("t3_data", d, 32'h0);
    repeat (2) @(negedge clk);
    check("t3_nobus", 32'(bv_seen), 32'd0);

    issue(0, 1'b0, 1'b0, 32'h2000_A000, 32'h0, 4'hF);
    wait_rsp(0, e, d, l);
    check("t4_hole", 32'(e), 32'd1);
    check("t4_hole_lat", 32'(l), 32'd2);
    issue(1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
    wait_rsp(1, e, d, l);
    check("t4_cached", 32'(e), 32'd1);
    issue(0, 1'b1, 1'b0, 32'h2000_A000, 32'h0, 4'hF);
    wait_rsp(0, e, d, l);
    check("t4_prio", 32'(e), 32'd1);
    rsp_data = 32'hFFFF_FFFF;
    rsp_err = 1'b1;
    issue(1, 1'b0, 1'b0, 32'h2000_0020, 32'h0, 4'hF);
    wait_rsp(1, e, d, l);
    check("t4_buserr", 32'(e), 32'd1);
    check("t4_buserr_d", d, 32'h0);
    check("t4_buserr_lat", 32'(l), 32'd4);
    rsp_err = 1'b0;

    ready_en = 1'b0;
    issue(1, 1'b0, 1'b0, 32'h2000_0030, 32'h0, 4'hF);
    wait_rsp(1, e, d, l);
    check("t5_err", 32'(e), 32'd3);
    check("t5_lat", 32'(l), 32'd10);
    check("t5_data", d, 32'h0);
    check("t5_busv", 32'(bus_valid_o), 32'd0);
    ready_en = 1'b1;
    rc = rsp_cnt;
    late_rsp = 1'b1;
    repeat (4) @(negedge clk);
    late_rsp = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_late", 32'(rsp_cnt), 32'(rc));
    rsp_data = 32'h1111_2222;
    issue(0, 1'b0, 1'b0, 32'h2000_0040, 32'h0, 4'hF);
    wait_rsp(0, e, d, l);
    check("t5_after", d, 32'h1111_2222);
    check("t5_after_err", 32'(e), 32'd0);

    rsp_en = 1'b0;
    issue(1, 1'b0, 1'b0, 32'h2000_0050, 32'h0, 4'hF);
    for (int k = 0; k < 20 && !pend; k++) begin
      @(negedge clk);
      req_valid_i[1] = 1'b0;
      #3;
    end
    check("t6_pend", 32'(pend), 32'd1);
    @(negedge clk);
    #2;
    req_valid_i = 2'b11;
    rst_ni = 1'b0;
    #1;
    check("t6_ready", 32'(req_ready_o), 32'd0);
    check("t6_rspv", 32'(rsp_valid_o), 32'd0);
    check("t6_busv", 32'(bus_valid_o), 32'd0);
    check("t6_pma", pma_addr_o, 32'd0);
    check("t6_err", 32'(rsp_err_o), 32'd0);
    check("t6_data", rsp_rdata_o, 32'd0);
    repeat (2) @(negedge clk);
    req_valid_i = 2'b00;
    rsp_en = 1'b1;
    rst_ni = 1'b1;
    rc = rsp_cnt;
    repeat (6) @(negedge clk);
    check("t6_stale", 32'(rsp_cnt), 32'(rc));
    gq.delete();
    @(negedge clk);
    req_valid_i = 2'b11;
    wait_grants(1);
    @(negedge clk);
    req_valid_i = 2'b00;
    check("t6_rr", 32'((gq.size() > 0) ? gq[0] : 99),
          32'd0);
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
